// File: rtl/decode_buffer.sv
// ---------------------------------------------------------------------------
// decode_buffer
//
// Small circular buffer between instruction fetch and decode. Fetch pushes
// {pc, instr} pairs and decode pops them in order. The head entry is shown
// together with its sequential next pc: +4 for a 32-bit encoding and +2 for
// a compressed one.
//
// Optional feature macro: DECODE_BUFFER_BYPASS_EN
//   undefined (default): no combinational path from in_* to out_*. A pushed
//                        entry is visible one cycle after the push.
//   defined            : when the buffer is empty, an offered entry is shown
//                        on the outputs in the same cycle. If decode takes it
//                        in that cycle, the entry is never stored.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. The producer holds its payload stable while valid=1 and ready=0.
// in_ready depends only on the occupancy (never on out_ready). out_valid
// depends on occupancy and flush, and also on in_valid when bypass is built in.
//
// Ports
//   clock        single clock; all state changes on the rising edge
//   reset        asynchronous, active-high; empties the buffer
//   flush        pipeline clear; empties the buffer at the next edge and
//                suppresses out_valid and any push in the current cycle
//   in_valid     fetch offers an entry
//   in_pc        pc of the offered entry
//   in_instr     instruction word of the offered entry
//   in_ready     buffer can accept an entry (count < DEPTH)
//   out_valid    head entry is valid for decode
//   out_pc       head pc (0 while out_valid=0)
//   out_instr    head instruction (nop 0x00000013 while out_valid=0)
//   out_npc      head next-sequential pc (4 while out_valid=0)
//   out_ready    decode consumes the head this cycle
//   count        current occupancy, 0..DEPTH
//   almost_full  count >= AFULL_LEVEL
//
// Parameters
//   DEPTH        number of entries; must be a power of two and at least 2
//   AFULL_LEVEL  occupancy threshold for almost_full, 1..DEPTH
// ---------------------------------------------------------------------------
module decode_buffer #(
    parameter int DEPTH       = 4,
    parameter int AFULL_LEVEL = 3
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [31:0]              in_pc,
    input  logic [31:0]              in_instr,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_instr,
    output logic [31:0]              out_npc,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     almost_full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Storage. It is never reset: the pointers and count alone define
    // which slots hold live entries.
    logic [31:0]    mem_pc    [DEPTH];
    logic [31:0]    mem_instr [DEPTH];

    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic [CW-1:0]  occ;

    logic           empty;
    logic           full;
    logic           stored_valid;
    logic           bypass_sel;
    logic           push;
    logic           pop;

    logic [31:0]    head_pc;
    logic [31:0]    head_instr;

    // -----------------------------------------------------------------------
    // Occupancy-derived status
    // -----------------------------------------------------------------------
    assign empty        = (occ == '0);
    assign full         = (occ == CW'(DEPTH));
    assign in_ready     = !full;
    assign count        = occ;
    assign almost_full  = (occ >= CW'(AFULL_LEVEL));

    // A stored head is only visible when not flushing. Flush masks it
    // combinationally so decode never takes an entry that is being discarded.
    assign stored_valid = !empty && !flush;

`ifdef DECODE_BUFFER_BYPASS_EN
    // Show the incoming entry directly when nothing is stored ahead of it.
    assign bypass_sel   = empty && in_valid && !flush;
`else
    assign bypass_sel   = 1'b0;
`endif

    assign out_valid    = stored_valid || bypass_sel;

    // A bypassed entry that decode takes in the same cycle is not stored.
    // When bypass is not built in, bypass_sel is constant 0 and this term
    // has no effect.
    assign push = in_valid && in_ready && !flush && !(bypass_sel && out_ready);
    assign pop  = stored_valid && out_ready;

    // -----------------------------------------------------------------------
    // Head selection and next-pc computation
    // -----------------------------------------------------------------------
    always_comb begin
        head_pc    = 32'h0;
        head_instr = NOP_INSTR;
        if (stored_valid) begin
            head_pc    = mem_pc[rd_ptr];
            head_instr = mem_instr[rd_ptr];
        end else if (bypass_sel) begin
            head_pc    = in_pc;
            head_instr = in_instr;
        end
    end

    assign out_pc    = head_pc;
    assign out_instr = head_instr;

    // The idle nop has low bits 2'b11, so the idle value of out_npc is
    // 0 + 4 = 4 with no special case. The add wraps modulo 2^32.
    assign out_npc   = head_pc + ((head_instr[1:0] == 2'b11) ? 32'd4 : 32'd2);

    // -----------------------------------------------------------------------
    // Pointers and occupancy
    // -----------------------------------------------------------------------
    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + CW'(1);
                2'b01:   occ <= occ - CW'(1);
                default: occ <= occ;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Storage write port
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (push) begin
            mem_pc[wr_ptr]    <= in_pc;
            mem_instr[wr_ptr] <= in_instr;
        end
    end

endmodule

// File: tb/tb_decode_buffer.sv
module tb_decode_buffer;

    localparam int DEPTH       = 4;
    localparam int AFULL_LEVEL = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [31:0] out_npc;
    logic        out_ready;
    logic [2:0]  count;
    logic        almost_full;

    int checks   = 0;
    int failures = 0;

    // Expected entries in output order: {pc, instr, npc}.
    logic [95:0] exp_q[$];
    logic [95:0] mon_e;
    int          m_cnt = 0;

    decode_buffer #(.DEPTH(DEPTH), .AFULL_LEVEL(AFULL_LEVEL)) dut (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_pc       (in_pc),
        .in_instr    (in_instr),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_pc      (out_pc),
        .out_instr   (out_instr),
        .out_npc     (out_npc),
        .out_ready   (out_ready),
        .count       (count),
        .almost_full (almost_full)
    );

    // ---------------------------------------------------------------- clock
    always #5 clock = ~clock;

    // ------------------------------------------------------------- checking
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Monitor: whenever decode takes the head, compare it with the queue front.
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output actual_pc=0x%08h required=no_entry", out_pc);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_pc",    out_pc,    mon_e[95:64]);
                check("out_instr", out_instr, mon_e[63:32]);
                check("out_npc",   out_npc,   mon_e[31:0]);
            end
        end
    end

    // --------------------------------------------------------------- driver
    // One clock cycle of stimulus. Status outputs are checked at the negedge
    // against the occupancy model. At the posedge, the model and the
    // expected queue are updated.
    task automatic step(input logic iv, input logic [31:0] pc, input logic [31:0] instr,
                        input logic [31:0] npc, input logic ordy, input logic fl,
                        input string tag);
        logic exp_ov;
        logic do_push;
        logic do_pop;
        in_valid  = iv;
        in_pc     = pc;
        in_instr  = instr;
        out_ready = ordy;
        flush     = fl;
        @(negedge clock);
        exp_ov = (m_cnt != 0) && !fl;
        check({tag, "_count"},       32'(count),       32'(m_cnt));
        check({tag, "_in_ready"},    32'(in_ready),    32'(m_cnt < DEPTH));
        check({tag, "_almost_full"}, 32'(almost_full), 32'(m_cnt >= AFULL_LEVEL));
        check({tag, "_out_valid"},   32'(out_valid),   32'(exp_ov));
        if (!exp_ov) begin
            check({tag, "_idle_pc"},    out_pc,    32'h0);
            check({tag, "_idle_instr"}, out_instr, 32'h0000_0013);
            check({tag, "_idle_npc"},   out_npc,   32'h4);
        end
        @(posedge clock);
        if (fl) begin
            exp_q.delete();
            m_cnt = 0;
        end else begin
            do_push = iv && (m_cnt < DEPTH);
            do_pop  = (m_cnt != 0) && ordy;
            if (do_push) exp_q.push_back({pc, instr, npc});
            m_cnt = m_cnt + int'(do_push) - int'(do_pop);
        end
        #1;
    endtask

    task automatic idle(input int n, input logic ordy, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 32'h0, ordy, 1'b0, tag);
    endtask

    // ------------------------------------------------------------- stimulus
    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = 32'h0;
        in_instr  = 32'h0;
        out_ready = 1'b0;

        // Reset values
        #2;
        check("rst_in_ready",    32'(in_ready),    32'h1);
        check("rst_out_valid",   32'(out_valid),   32'h0);
        check("rst_almost_full", 32'(almost_full), 32'h0);
        check("rst_count",       32'(count),       32'h0);
        check("rst_out_pc",      out_pc,           32'h0);
        check("rst_out_instr",   out_instr,        32'h0000_0013);
        check("rst_out_npc",     out_npc,          32'h4);
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b0;

        // Fill with decode stalled: the fifth push is rejected.
        step(1'b1, 32'h0,  32'h13, 32'h4,  1'b0, 1'b0, "fill0");
        step(1'b1, 32'h4,  32'h13, 32'h8,  1'b0, 1'b0, "fill1");
        step(1'b1, 32'h8,  32'h13, 32'hC,  1'b0, 1'b0, "fill2");
        step(1'b1, 32'hC,  32'h13, 32'h10, 1'b0, 1'b0, "fill3");
        step(1'b1, 32'h10, 32'h13, 32'h14, 1'b0, 1'b0, "fill4");
        #1;
        check("fill_count_full",  32'(count),       32'h4);
        check("fill_in_ready",    32'(in_ready),    32'h0);
        check("fill_almost_full", 32'(almost_full), 32'h1);
        idle(5, 1'b1, "drain_fill");
        check("drain_fill_empty", 32'(exp_q.size()), 32'h0);

        // Next-pc: compressed encoding and wrap at the top of the address space.
        step(1'b1, 32'h100,       32'h0000_4501, 32'h102, 1'b0, 1'b0, "npc_c");
        step(1'b1, 32'hFFFF_FFFC, 32'h0000_0013, 32'h0,   1'b0, 1'b0, "npc_wrap");
        idle(3, 1'b1, "drain_npc");
        check("drain_npc_empty", 32'(exp_q.size()), 32'h0);

        // No bypass: an entry pushed into an empty buffer appears one cycle later.
        step(1'b1, 32'h200, 32'h13, 32'h204, 1'b1, 1'b0, "lat_push");
        #1;
        check("lat_out_valid_next", 32'(out_valid), 32'h1);
        check("lat_out_pc_next",    out_pc,         32'h200);
        check("lat_count_next",     32'(count),     32'h1);
        idle(2, 1'b1, "lat_drain");
        check("lat_drain_empty", 32'(exp_q.size()), 32'h0);

        // Streaming at count=2: pointers wrap and order is preserved.
        step(1'b1, 32'h1000, 32'h13, 32'h1004, 1'b0, 1'b0, "st_pre0");
        step(1'b1, 32'h1004, 32'h0000_4501, 32'h1006, 1'b0, 1'b0, "st_pre1");
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 32'h1008 + 32'(4 * i), 32'h13, 32'h100C + 32'(4 * i), 1'b1, 1'b0, "stream");
            check("stream_count", 32'(count), 32'h2);
        end
        idle(3, 1'b1, "st_drain");
        check("st_drain_empty", 32'(exp_q.size()), 32'h0);

        // Flush while full, with a push offered in the same cycle.
        for (int i = 0; i < 4; i++)
            step(1'b1, 32'h2000 + 32'(4 * i), 32'h13, 32'h2004 + 32'(4 * i), 1'b0, 1'b0, "fl_fill");
        in_valid  = 1'b1;
        in_pc     = 32'h3000;
        in_instr  = 32'h13;
        out_ready = 1'b1;
        flush     = 1'b1;
        #1;
        check("flush_out_valid", 32'(out_valid), 32'h0);
        step(1'b1, 32'h3000, 32'h13, 32'h3004, 1'b1, 1'b1, "flush");
        flush = 1'b0;
        #1;
        check("post_flush_count",    32'(count),    32'h0);
        check("post_flush_in_ready", 32'(in_ready), 32'h1);
        idle(3, 1'b1, "post_flush");

        // Reset asserted mid-stream with three entries stored.
        step(1'b1, 32'h4000, 32'h13, 32'h4004, 1'b0, 1'b0, "mr0");
        step(1'b1, 32'h4004, 32'h13, 32'h4008, 1'b0, 1'b0, "mr1");
        step(1'b1, 32'h4008, 32'h13, 32'h400C, 1'b0, 1'b0, "mr2");
        in_valid = 1'b0;
        check("mr_count_before", 32'(count), 32'h3);
        #1 reset = 1'b1;
        #1;
        check("mr_count",     32'(count),     32'h0);
        check("mr_out_valid", 32'(out_valid), 32'h0);
        check("mr_out_instr", out_instr,      32'h0000_0013);
        check("mr_in_ready",  32'(in_ready),  32'h1);
        exp_q.delete();
        m_cnt = 0;
        @(posedge clock);
        #1 reset = 1'b0;
        idle(3, 1'b1, "after_reset");
        check("final_queue_empty", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
